hwpf_stride_ctrl: RTL and testbench
===================================

# hwpf_stride_ctrl

Sequencing controller for one stride-prefetch stream of the hardware prefetcher. It holds the stream's base cache line, stride and burst length, and arms an internal `hwpf_stride_snooper` instance. When a snooped access hits the base line, it issues a burst of prefetch requests (base+stride, base+2·stride, …) over a valid/ready port toward the prefetch arbiter. It sits between the configuration CSRs and the prefetch request arbiter.

## Interface
- `STRIDE_W`, default 16: width of the stride, in cache lines; unsigned.
- `NBLK_W`, default 4: width of the burst-length field; a burst is `cfg_nblocks_i + 1` requests.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock; asynchronous and active-high.
- `cfg_en_i`  in  1  stream enable level.
- `cfg_set_i`  in  1  one-cycle pulse: load the base, stride and nblocks registers.
- `cfg_base_nline_i`  in  hpdcache_nline_t  new base line.
- `cfg_stride_i`  in  STRIDE_W  new stride.
- `cfg_nblocks_i`  in  NBLK_W  new burst length minus one.
- `snoop_valid_i`  in  1  the snooped access is valid this cycle.
- `snoop_nline_i`  in  hpdcache_nline_t  line address of the snooped access.
- `req_valid_o`  out  1  prefetch request valid.
- `req_ready_i`  in  1  arbiter accepts the request.
- `req_nline_o`  out  hpdcache_nline_t  line to prefetch.
- `armed_o`  out  1  the snooper is enabled (state ARMED).
- `busy_o`  out  1  a burst is in progress (state ISSUE).

## Operation
- States: IDLE, ARMED, ISSUE.
  - IDLE → ARMED when `cfg_en_i`=1.
  - ARMED → IDLE when `cfg_en_i`=0.
  - ARMED → ISSUE on match = `snoop_valid_i` & snooper match.
  - ARMED → ARMED when `cfg_set_i`=1 and no match that cycle.
- The snooper enable is `armed_o`. It compares the `base` register against `snoop_nline_i`.
- On entering ISSUE:
  - `cur` ← base + stride, where stride is zero-extended.
  - `cnt` ← nblocks.
- In ISSUE:
  - `req_valid_o`=1 and `req_nline_o`=`cur`.
  - On handshake (valid & ready): if `cnt`≠0, then `cur` += stride and `cnt` −= 1. Otherwise the burst ends.
- Burst end:
  - With the rearm macro: `base` ← last issued `cur`, then → ARMED if `cfg_en_i`=1, else → IDLE.
  - Without the rearm macro: → IDLE. `base` is unchanged.
- Line arithmetic is modulo 2^width(hpdcache_nline_t). Wrap-around is silent.
- A stride of 0 is legal. The burst repeats the base line nblocks+1 times.
- `cfg_set_i` in IDLE/ARMED: registers load on that edge. A match in the same cycle uses the old base, and the burst uses the old stride/nblocks (priority: match captures the old values first). New values apply from the next cycle.
- `cfg_set_i` or `cfg_en_i`=0 during ISSUE:
  - The current request is held stable until its handshake.
  - The burst is then abandoned, whatever `cnt` is.
  - Next state is ARMED with the new base if `cfg_en_i`=1, else IDLE.
  - A `cfg_set_i` arriving during ISSUE is latched into the config registers immediately. It never alters `req_nline_o` mid-handshake.
- Snoops are ignored in ISSUE. No queueing.

## Timing
- Reset values:
  - `req_valid_o`=0, `req_nline_o`=0, `armed_o`=0, `busy_o`=0.
  - State is IDLE; base, stride, nblocks, cur and cnt are 0.
- Reset asserted mid-burst drops `req_valid_o` immediately (asynchronously). There is no completion.
- Latency:
  - Match in cycle N → first `req_valid_o` in N+1.
  - Handshake in cycle M → next request in M+1. Throughput is 1 request/cycle with `req_ready_i` held high.
- Burst end:
  - Last handshake in cycle M → `armed_o`=1 in M+1.
  - The earliest re-trigger is a match in M+1, giving a request in M+2.
- Valid/ready rules: once asserted, `req_valid_o` and `req_nline_o` stay stable until `req_ready_i`=1. `req_valid_o` never depends combinationally on `req_ready_i`.
- All outputs are registered.

## Configuration
- `HPDCACHE_HWPF_STRIDE_REARM_EN`
  - Defined: continuous streaming. After each burst, the base advances to the last prefetched line and the controller re-arms.
  - Undefined: one-shot. One burst per `cfg_set_i`/enable cycle. The base is never modified by the controller, and the controller goes to IDLE after the burst. It re-arms only after `cfg_en_i` is deasserted and then reasserted.

## Test plan
- Basic burst:
  - Stimulus: base=0x100, stride=2, nblocks=3, enable; snoop 0x100 with `req_ready_i`=1.
  - Response: requests 0x102, 0x104, 0x106, 0x108 on consecutive cycles, starting 1 cycle after the match. With REARM, then `armed_o`=1 and base=0x108.
- Backpressure:
  - Stimulus: same burst with `req_ready_i` low for 3 cycles at each request.
  - Response: `req_nline_o` stable while valid and not ready. 4 requests total, no duplicates.
- No-match and disable cases:
  - Snoop 0x101, or snoop with `snoop_valid_i`=0 → no request.
  - `cfg_en_i`=0 → `armed_o`=0 next cycle, and a snoop of 0x100 is ignored.
- Wrap-around:
  - Stimulus: base = all-ones−1, stride=3, nblocks=0, match.
  - Response: single request at line 1.
- Mid-burst reconfiguration:
  - Stimulus: `cfg_set_i` (base=0x200) during the 2nd request of the burst, `req_ready_i`=0.
  - Response: the 2nd request is held, then accepted; no 3rd request. `armed_o`=1 with base 0x200. A snoop of 0x200 triggers a new burst.
- Asynchronous reset:
  - Stimulus: `rst_i` asserted mid-burst.
  - Response: `req_valid_o`=0 immediately and all outputs at their reset values. After release, snoops are ignored until `cfg_en_i`=1.

Source files
------------

// File: rtl/hwpf_stride_ctrl.sv
// Stride-prefetch stream sequencer: snoop match on base line -> burst of nblocks+1 line requests.
// Latency: match N -> first request N+1, 1 req/cycle; requests held stable under !req_ready_i.
// Optional HPDCACHE_HWPF_STRIDE_REARM_EN: advance base to last issued line and re-arm after each burst.

module hwpf_stride_snooper #(
   parameter int NLINE_W = 26
) (
   input  logic               en_i,
   input  logic [NLINE_W-1:0] base_nline_i,
   input  logic               snoop_valid_i,
   input  logic [NLINE_W-1:0] snoop_nline_i,
   output logic               match_o
);
   assign match_o = en_i & snoop_valid_i & (snoop_nline_i == base_nline_i);
endmodule

module hwpf_stride_ctrl #(
   parameter int NLINE_W  = 26,
   parameter int STRIDE_W = 16,
   parameter int NBLK_W   = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_en_i,
   input  logic                cfg_set_i,
   input  logic [NLINE_W-1:0]  cfg_base_nline_i,
   input  logic [STRIDE_W-1:0] cfg_stride_i,
   input  logic [NBLK_W-1:0]   cfg_nblocks_i,
   input  logic                snoop_valid_i,
   input  logic [NLINE_W-1:0]  snoop_nline_i,
   output logic                req_valid_o,
   input  logic                req_ready_i,
   output logic [NLINE_W-1:0]  req_nline_o,
   output logic                armed_o,
   output logic                busy_o
);
   typedef enum logic [1:0] {IDLE, ARMED, ISSUE} state_e;

   state_e              state_q, state_d;
   logic [NLINE_W-1:0]  base_q, base_d;
   logic [STRIDE_W-1:0] stride_q, stride_d;
   logic [NBLK_W-1:0]   nblk_q, nblk_d;
   logic [NLINE_W-1:0]  cur_q, cur_d;
   logic [NBLK_W-1:0]   cnt_q, cnt_d;
   logic                abort_q, abort_d;
   logic                match, hs, abort_now;
   logic [NLINE_W-1:0]  stride_ext;
`ifndef HPDCACHE_HWPF_STRIDE_REARM_EN
   // One-shot: blocks re-arming until the enable is dropped.
   logic                done_q, done_d;
`endif

   hwpf_stride_snooper #(.NLINE_W(NLINE_W)) u_snooper (
      .en_i          (armed_o),
      .base_nline_i  (base_q),
      .snoop_valid_i (snoop_valid_i),
      .snoop_nline_i (snoop_nline_i),
      .match_o       (match)
   );

   assign req_valid_o = (state_q == ISSUE);
   assign busy_o      = (state_q == ISSUE);
   assign armed_o     = (state_q == ARMED);
   assign req_nline_o = cur_q;
   assign stride_ext  = NLINE_W'(stride_q);
   assign hs          = req_valid_o & req_ready_i;
   assign abort_now   = abort_q | cfg_set_i | ~cfg_en_i;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      stride_d = stride_q;
      nblk_d   = nblk_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      abort_d  = abort_q;
`ifndef HPDCACHE_HWPF_STRIDE_REARM_EN
      done_d   = done_q & cfg_en_i;
`endif
      // A match this cycle captures the old registers, which are read from _q below.
      if (cfg_set_i) begin
         base_d   = cfg_base_nline_i;
         stride_d = cfg_stride_i;
         nblk_d   = cfg_nblocks_i;
      end
      case (state_q)
         IDLE: begin
`ifdef HPDCACHE_HWPF_STRIDE_REARM_EN
            if (cfg_en_i) state_d = ARMED;
`else
            if (cfg_en_i && !done_q) state_d = ARMED;
`endif
         end
         ARMED: begin
            if (!cfg_en_i) begin
               state_d = IDLE;
            end else if (match) begin
               state_d = ISSUE;
               cur_d   = base_q + stride_ext;
               cnt_d   = nblk_q;
               abort_d = 1'b0;
            end
         end
         ISSUE: begin
            if (!hs) begin
               abort_d = abort_now;
            end else if (abort_now) begin
               state_d = cfg_en_i ? ARMED : IDLE;
               abort_d = 1'b0;
            end else if (cnt_q != '0) begin
               cur_d = cur_q + stride_ext;
               cnt_d = cnt_q - 1'b1;
            end else begin
`ifdef HPDCACHE_HWPF_STRIDE_REARM_EN
               base_d  = cur_q;
               state_d = ARMED;
`else
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         base_q   <= '0;
         stride_q <= '0;
         nblk_q   <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         abort_q  <= 1'b0;
`ifndef HPDCACHE_HWPF_STRIDE_REARM_EN
         done_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         stride_q <= stride_d;
         nblk_q   <= nblk_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         abort_q  <= abort_d;
`ifndef HPDCACHE_HWPF_STRIDE_REARM_EN
         done_q   <= done_d;
`endif
      end
   end
endmodule

// File: tb/tb_hwpf_stride_ctrl.sv
// Directed bench for hwpf_stride_ctrl: vector table plus hand-written burst/backpressure/reset sequences.
module tb_hwpf_stride_ctrl;
   localparam int NW = 26;
`ifdef HPDCACHE_HWPF_STRIDE_REARM_EN
   localparam logic REARM = 1'b1;
`else
   localparam logic REARM = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_en, cfg_set, snoop_valid, req_ready;
   logic [NW-1:0] cfg_base, snoop_nline;
   logic [15:0]   cfg_stride;
   logic [3:0]    cfg_nblocks;
   logic          req_valid, armed, busy;
   logic [NW-1:0] req_nline;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   hwpf_stride_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cfg_en_i         (cfg_en),
      .cfg_set_i        (cfg_set),
      .cfg_base_nline_i (cfg_base),
      .cfg_stride_i     (cfg_stride),
      .cfg_nblocks_i    (cfg_nblocks),
      .snoop_valid_i    (snoop_valid),
      .snoop_nline_i    (snoop_nline),
      .req_valid_o      (req_valid),
      .req_ready_i      (req_ready),
      .req_nline_o      (req_nline),
      .armed_o          (armed),
      .busy_o           (busy)
   );

   typedef struct packed {
      logic          en;
      logic          set;
      logic          sv;
      logic [NW-1:0] sn;
      logic          rdy;
      logic          ev;
      logic [NW-1:0] enl;
      logic          ea;
      logic          eb;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(input logic en, input logic set, input logic sv,
                               input logic [NW-1:0] sn, input logic rdy, input logic ev,
                               input logic [NW-1:0] enl, input logic ea, input logic eb);
      vec_t v;
      v.en = en; v.set = set; v.sv = sv; v.sn = sn; v.rdy = rdy;
      v.ev = ev; v.enl = enl; v.ea = ea; v.eb = eb;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic set, input logic [NW-1:0] base,
                        input logic [15:0] stride, input logic [3:0] nblk,
                        input logic sv, input logic [NW-1:0] sn, input logic rdy);
      cfg_en = en; cfg_set = set; cfg_base = base; cfg_stride = stride;
      cfg_nblocks = nblk; snoop_valid = sv; snoop_nline = sn; req_ready = rdy;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic check_out(input string nm, input logic ev, input logic [NW-1:0] enl,
                            input logic ea, input logic eb);
      check({nm, " valid"}, {31'd0, req_valid}, {31'd0, ev});
      if (ev) check({nm, " nline"}, {6'd0, req_nline}, {6'd0, enl});
      check({nm, " armed"}, {31'd0, armed}, {31'd0, ea});
      check({nm, " busy"}, {31'd0, busy}, {31'd0, eb});
   endtask

   initial begin
      //              en  set sv  sn        rdy ev  enl       ea     eb
      tbl[0]  = mk(1'b0,1'b1,1'b0,26'h0,  1'b0,1'b0,26'h0,  1'b0,  1'b0);
      tbl[1]  = mk(1'b1,1'b0,1'b0,26'h0,  1'b0,1'b0,26'h0,  1'b1,  1'b0);
      tbl[2]  = mk(1'b1,1'b0,1'b1,26'h101,1'b0,1'b0,26'h0,  1'b1,  1'b0);
      tbl[3]  = mk(1'b1,1'b0,1'b0,26'h100,1'b0,1'b0,26'h0,  1'b1,  1'b0);
      tbl[4]  = mk(1'b1,1'b0,1'b1,26'h100,1'b1,1'b1,26'h102,1'b0,  1'b1);
      tbl[5]  = mk(1'b1,1'b0,1'b0,26'h0,  1'b1,1'b1,26'h104,1'b0,  1'b1);
      tbl[6]  = mk(1'b1,1'b0,1'b0,26'h0,  1'b1,1'b1,26'h106,1'b0,  1'b1);
      tbl[7]  = mk(1'b1,1'b0,1'b0,26'h0,  1'b1,1'b1,26'h108,1'b0,  1'b1);
      tbl[8]  = mk(1'b1,1'b0,1'b0,26'h0,  1'b1,1'b0,26'h0,  REARM, 1'b0);
      tbl[9]  = mk(1'b1,1'b0,1'b0,26'h0,  1'b0,1'b0,26'h0,  REARM, 1'b0);
      tbl[10] = mk(1'b0,1'b0,1'b0,26'h0,  1'b0,1'b0,26'h0,  1'b0,  1'b0);
      tbl[11] = mk(1'b1,1'b0,1'b0,26'h0,  1'b0,1'b0,26'h0,  1'b1,  1'b0);
      tbl[12] = mk(1'b0,1'b0,1'b1,26'h100,1'b0,1'b0,26'h0,  1'b0,  1'b0);
      tbl[13] = mk(1'b0,1'b0,1'b1,26'h100,1'b0,1'b0,26'h0,  1'b0,  1'b0);

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 1'b0, '0, 1'b0, 1'b0);
      check("reset nline", {6'd0, req_nline}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic burst, no-match, disable cases.
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].en, tbl[i].set, 26'h100, 16'd2, 4'd3, tbl[i].sv, tbl[i].sn, tbl[i].rdy);
         step();
         check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].enl, tbl[i].ea, tbl[i].eb);
      end

      // Backpressure: 3 stall cycles per request, request must not move.
      drive(1, 1, 26'h100, 16'd2, 4'd3, 0, 0, 0);
      step();
      check_out("bp arm", 1'b0, '0, 1'b1, 1'b0);
      drive(1, 0, 26'h100, 16'd2, 4'd3, 1, 26'h100, 0);
      step();
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 26'h100, 16'd2, 4'd3, 0, 0, 0);
         for (int s = 0; s < 3; s++) begin
            step();
            check_out($sformatf("bp req%0d stall%0d", k, s), 1'b1, 26'h102 + NW'(2 * k), 1'b0, 1'b1);
         end
         req_ready = 1'b1;
         step();
      end
      check_out("bp end", 1'b0, '0, REARM, 1'b0);

      // Wrap-around of line arithmetic.
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check_out("wrap idle", 1'b0, '0, 1'b0, 1'b0);
      drive(1, 1, 26'h3FFFFFE, 16'd3, 4'd0, 0, 0, 0);
      step();
      check_out("wrap arm", 1'b0, '0, 1'b1, 1'b0);
      drive(1, 0, 26'h3FFFFFE, 16'd3, 4'd0, 1, 26'h3FFFFFE, 1);
      step();
      check_out("wrap req", 1'b1, 26'h1, 1'b0, 1'b1);
      drive(1, 0, 26'h0, 16'd3, 4'd0, 0, 0, 1);
      step();
      check_out("wrap end", 1'b0, '0, REARM, 1'b0);

      // Mid-burst reconfiguration during a stalled 2nd request.
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 1, 26'h100, 16'd2, 4'd3, 0, 0, 0);
      step();
      check_out("mid arm", 1'b0, '0, 1'b1, 1'b0);
      drive(1, 0, 26'h100, 16'd2, 4'd3, 1, 26'h100, 1);
      step();
      check_out("mid req0", 1'b1, 26'h102, 1'b0, 1'b1);
      drive(1, 0, 26'h100, 16'd2, 4'd3, 0, 0, 1);
      step();
      check_out("mid req1", 1'b1, 26'h104, 1'b0, 1'b1);
      drive(1, 1, 26'h200, 16'd2, 4'd3, 0, 0, 0);
      step();
      check_out("mid set hold", 1'b1, 26'h104, 1'b0, 1'b1);
      drive(1, 0, 26'h0, 16'd2, 4'd3, 0, 0, 0);
      step();
      check_out("mid hold", 1'b1, 26'h104, 1'b0, 1'b1);
      req_ready = 1'b1;
      step();
      check_out("mid abandon", 1'b0, '0, 1'b1, 1'b0);
      step();
      check_out("mid no 3rd", 1'b0, '0, 1'b1, 1'b0);
      drive(1, 0, 26'h0, 16'd2, 4'd3, 1, 26'h200, 1);
      step();
      check_out("new base req0", 1'b1, 26'h202, 1'b0, 1'b1);
      drive(1, 0, 26'h0, 16'd2, 4'd3, 0, 0, 1);
      step();
      check_out("new base req1", 1'b1, 26'h204, 1'b0, 1'b1);

      // Asynchronous reset mid-burst.
      #2;
      rst = 1'b1;
      #1;
      check_out("async rst", 1'b0, '0, 1'b0, 1'b0);
      check("async rst nline", {6'd0, req_nline}, 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 1, 26'h0, 1);
      step();
      check_out("post rst snoop0", 1'b0, '0, 1'b0, 1'b0);
      drive(0, 0, 0, 0, 0, 1, 26'h200, 1);
      step();
      check_out("post rst snoop200", 1'b0, '0, 1'b0, 1'b0);
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      step();
      check_out("post rst arm", 1'b0, '0, 1'b1, 1'b0);
      drive(1, 0, 0, 0, 0, 1, 26'h0, 1);
      step();
      check_out("zero stride req", 1'b1, 26'h0, 1'b0, 1'b1);
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      step();
      check_out("zero stride end", 1'b0, '0, REARM, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
